packet_mem_writer: RTL and testbench

//  Ingress stage directly upstream of the packet-memory dual-port BRAM.

---
 rtl/packet_mem_writer_pkg.sv | 10 +
 rtl/packet_mem_writer_sat_counter.sv | 19 +
 rtl/packet_mem_writer.sv | 136 +++++++++++++
 tb/tb_packet_mem_writer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/packet_mem_writer_pkg.sv
// packet_mem_writer_pkg: FSM state encoding shared by the packet-memory ingress writer
package packet_mem_writer_pkg;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READY   = 3'd1,
      WRITING = 3'd2,
      DONE    = 3'd3,
      DROP    = 3'd4
   } state_e;
endpackage

// File: rtl/packet_mem_writer_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones
//  clk   : clock
//  rst_n : asynchronous active-low reset, clears the count
//  inc   : increment request for this cycle
//  cnt   : current count
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   logic [W-1:0] cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else if (inc && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
   assign cnt = cnt_q;
endmodule

// File: rtl/packet_mem_writer.sv
// packet_mem_writer: snoops a packet word stream and stores whole packets into one BRAM buffer
//  clk, rst_n          : clock, asynchronous active-low reset
//  snoop_data/vld/last : packet word stream, byte 0 in MSBs, no backpressure
//  snoop_bytes         : valid bytes in the last word (0 or >BPW means full word)
//  buf_rdy             : pulse handing an empty buffer to this block
//  wr_addr/data/en     : BRAM port A write, bram_en mirrors wr_en
//  pkt_done, pkt_len   : packet handed over with its byte length (len held until next done)
//  buf_owned           : this block currently holds the buffer
//  drop_cnt            : saturating count of discarded packets
module packet_mem_writer
   import packet_mem_writer_pkg::*;
#(
   parameter  int ADDR_WIDTH = 10,
   parameter  int PORT_WIDTH = 32,
   parameter  int CNT_WIDTH  = 16,
   localparam int BPW        = PORT_WIDTH / 8,
   localparam int SBW        = $clog2(BPW) + 1,
   localparam int LW         = ADDR_WIDTH + $clog2(BPW) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [PORT_WIDTH-1:0] snoop_data,
   input  logic                  snoop_vld,
   input  logic                  snoop_last,
   input  logic [SBW-1:0]        snoop_bytes,
   input  logic                  buf_rdy,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [PORT_WIDTH-1:0] wr_data,
   output logic                  wr_en,
   output logic                  bram_en,
   output logic                  pkt_done,
   output logic [LW-1:0]         pkt_len,
   output logic                  buf_owned,
   output logic [CNT_WIDTH-1:0]  drop_cnt
);
   state_e                state_q, state_d;
   logic                  sop_q;
   logic                  own_q, own_d;
   logic [ADDR_WIDTH:0]   idx_q, idx_d;
   logic [LW-1:0]         len_q, len_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [PORT_WIDTH-1:0] wr_data_q;
   logic                  pkt_done_q;
   logic [LW-1:0]         pkt_len_q;
   logic                  drop_inc;
   logic                  sop;
   logic [LW-1:0]         eff;
   // sop_q means "the previous valid word was a last", so it doubles as the post-reset sync flag
   assign sop = snoop_vld & sop_q;
   assign eff = (snoop_bytes == '0 || snoop_bytes > SBW'(BPW)) ? LW'(BPW) : LW'(snoop_bytes);
   always_comb begin
      state_d   = state_q;
      own_d     = own_q;
      idx_d     = idx_q;
      len_d     = len_q;
      wr_en_d   = 1'b0;
      wr_addr_d = idx_q[ADDR_WIDTH-1:0];
      drop_inc  = 1'b0;
      unique case (state_q)
         IDLE, DONE, READY: begin
            if (state_q != READY) state_d = buf_rdy ? READY : IDLE;
            if (sop && (state_q == READY || buf_rdy)) begin
               wr_en_d   = 1'b1;
               wr_addr_d = '0;
               idx_d     = 1;
               len_d     = eff;
               state_d   = snoop_last ? DONE : WRITING;
            end else if (sop) begin
               drop_inc = 1'b1;
               own_d    = 1'b0;
               state_d  = snoop_last ? IDLE : DROP;
            end
         end
         WRITING: if (snoop_vld) begin
            // idx_q reaching 2**ADDR_WIDTH means the buffer is full: this word would wrap
            if (idx_q[ADDR_WIDTH]) begin
               drop_inc = 1'b1;
               own_d    = 1'b1;
               state_d  = snoop_last ? READY : DROP;
            end else begin
               wr_en_d = 1'b1;
               idx_d   = idx_q + 1'b1;
               len_d   = LW'(idx_q) * LW'(BPW) + eff;
               if (snoop_last) state_d = DONE;
            end
         end
         DROP: begin
            // a buffer offered while discarding is kept so the next packet can use it
            own_d = own_q | buf_rdy;
            if (snoop_vld && snoop_last) state_d = own_d ? READY : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q    <= IDLE;
         sop_q      <= 1'b0;
         own_q      <= 1'b0;
         idx_q      <= '0;
         len_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         pkt_done_q <= 1'b0;
         pkt_len_q  <= '0;
      end else begin
         state_q    <= state_d;
         sop_q      <= snoop_vld ? snoop_last : sop_q;
         own_q      <= own_d;
         idx_q      <= idx_d;
         len_q      <= len_d;
         wr_en_q    <= wr_en_d;
         if (wr_en_d) begin
            wr_addr_q <= wr_addr_d;
            wr_data_q <= snoop_data;
         end
         // handoff one cycle after DONE, i.e. after the last word's write has landed
         pkt_done_q <= state_q == DONE;
         if (state_q == DONE) pkt_len_q <= len_q;
      end
   sat_counter #(.W(CNT_WIDTH)) u_drop (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (drop_inc),
      .cnt  (drop_cnt)
   );
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign wr_en     = wr_en_q;
   assign bram_en   = wr_en_q;
   assign pkt_done  = pkt_done_q;
   assign pkt_len   = pkt_len_q;
   assign buf_owned = state_q == READY || state_q == WRITING || (state_q == DROP && own_q);
endmodule

// File: tb/tb_packet_mem_writer.sv
// tb_packet_mem_writer: directed checks of packet_mem_writer with a 4-word buffer
module tb_packet_mem_writer;
   logic        clk = 0;
   logic        rst_n = 0;
   logic [31:0] snoop_data = 0;
   logic        snoop_vld = 0;
   logic        snoop_last = 0;
   logic [2:0]  snoop_bytes = 0;
   logic        buf_rdy = 0;
   logic [1:0]  wr_addr, s_wr_addr;
   logic [31:0] wr_data, s_wr_data;
   logic        wr_en, s_wr_en, bram_en, s_bram_en;
   logic        pkt_done, s_pkt_done;
   logic [4:0]  pkt_len, s_pkt_len;
   logic        buf_owned, s_buf_owned;
   logic [15:0] drop_cnt;
   logic [1:0]  s_drop_cnt;
   int          n_chk = 0;
   int          n_fail = 0;
   always #5 clk = ~clk;
   packet_mem_writer #(.ADDR_WIDTH(2), .PORT_WIDTH(32), .CNT_WIDTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .snoop_data(snoop_data), .snoop_vld(snoop_vld),
      .snoop_last(snoop_last), .snoop_bytes(snoop_bytes), .buf_rdy(buf_rdy),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .bram_en(bram_en),
      .pkt_done(pkt_done), .pkt_len(pkt_len), .buf_owned(buf_owned), .drop_cnt(drop_cnt)
   );
   packet_mem_writer #(.ADDR_WIDTH(2), .PORT_WIDTH(32), .CNT_WIDTH(2)) u_sat (
      .clk(clk), .rst_n(rst_n), .snoop_data(snoop_data), .snoop_vld(snoop_vld),
      .snoop_last(snoop_last), .snoop_bytes(snoop_bytes), .buf_rdy(buf_rdy),
      .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_en(s_wr_en), .bram_en(s_bram_en),
      .pkt_done(s_pkt_done), .pkt_len(s_pkt_len), .buf_owned(s_buf_owned), .drop_cnt(s_drop_cnt)
   );
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic send(input logic [31:0] d, input logic l, input logic [2:0] b, input logic r);
      snoop_data = d; snoop_vld = 1; snoop_last = l; snoop_bytes = b; buf_rdy = r;
      @(posedge clk); #1;
      snoop_vld = 0; snoop_last = 0; buf_rdy = 0;
   endtask
   task automatic idle(input logic r);
      buf_rdy = r;
      @(posedge clk); #1;
      buf_rdy = 0;
   endtask
   task automatic wr(input string tag, input logic [1:0] a, input logic [31:0] d);
      check({tag, "_en"}, wr_en, 1);
      check({tag, "_bram_en"}, bram_en, 1);
      check({tag, "_addr"}, wr_addr, a);
      check({tag, "_data"}, wr_data, d);
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_pkt_done", pkt_done, 0);
      check("rst_pkt_len", pkt_len, 0);
      check("rst_owned", buf_owned, 0);
      check("rst_drop", drop_cnt, 0);
      rst_n = 1;
      idle(0);
      // unsynced: a lone last word is discarded without counting
      send(32'h11111111, 1, 0, 0);
      check("sync_wr_en", wr_en, 0);
      check("sync_drop", drop_cnt, 0);
      // test 1: 3-word packet, 2 bytes in last word
      idle(1);
      check("t1_owned", buf_owned, 1);
      send(32'hA0A1A2A3, 0, 0, 0); wr("t1_w0", 0, 32'hA0A1A2A3);
      send(32'hB0B1B2B3, 0, 0, 0); wr("t1_w1", 1, 32'hB0B1B2B3);
      send(32'hC0C1C2C3, 1, 2, 0); wr("t1_w2", 2, 32'hC0C1C2C3);
      check("t1_done_early", pkt_done, 0);
      idle(0);
      check("t1_done", pkt_done, 1);
      check("t1_len", pkt_len, 10);
      check("t1_wr_idle", wr_en, 0);
      check("t1_released", buf_owned, 0);
      idle(0);
      check("t1_done_pulse", pkt_done, 0);
      check("t1_len_hold", pkt_len, 10);
      // test 2: no buffer, 4-word packet dropped
      for (int i = 0; i < 4; i++) begin
         send(32'hD0000000 + i, i == 3, 0, 0);
         check("t2_no_wr", wr_en, 0);
      end
      check("t2_drop", drop_cnt, 1);
      check("t2_drop_sat", s_drop_cnt, 1);
      idle(1);
      send(32'hE0E1E2E3, 1, 0, 0); wr("t2_w0", 0, 32'hE0E1E2E3);
      idle(0);
      check("t2_done", pkt_done, 1);
      check("t2_len", pkt_len, 4);
      // test 3: buf_rdy with SOP in the same cycle
      send(32'h12345678, 0, 0, 1); wr("t3_w0", 0, 32'h12345678);
      send(32'h9ABCDEF0, 1, 3, 0); wr("t3_w1", 1, 32'h9ABCDEF0);
      idle(0);
      check("t3_done", pkt_done, 1);
      check("t3_len", pkt_len, 7);
      // test 4: 6-word packet into a 4-word buffer
      idle(1);
      for (int i = 0; i < 4; i++) begin
         send(32'h40000000 + i, 0, 0, 0);
         wr("t4_w", 2'(i), 32'h40000000 + i);
      end
      send(32'h40000004, 0, 0, 0);
      check("t4_ovf_no_wr", wr_en, 0);
      check("t4_drop", drop_cnt, 2);
      check("t4_owned_drop", buf_owned, 1);
      send(32'h40000005, 1, 0, 0);
      check("t4_last_no_wr", wr_en, 0);
      idle(0);
      check("t4_no_done", pkt_done, 0);
      check("t4_owned", buf_owned, 1);
      send(32'h50505050, 0, 0, 0); wr("t4_r0", 0, 32'h50505050);
      send(32'h51515151, 1, 0, 0); wr("t4_r1", 1, 32'h51515151);
      idle(0);
      check("t4_done", pkt_done, 1);
      check("t4_len", pkt_len, 8);
      check("t4_drop_sat", s_drop_cnt, 2);
      // test 5: asynchronous reset in the middle of a packet
      idle(1);
      send(32'h60606060, 0, 0, 0); wr("t5_w0", 0, 32'h60606060);
      send(32'h61616161, 0, 0, 0); wr("t5_w1", 1, 32'h61616161);
      #2 rst_n = 0;
      #1;
      check("t5_rst_wr_en", wr_en, 0);
      check("t5_rst_addr", wr_addr, 0);
      check("t5_rst_owned", buf_owned, 0);
      check("t5_rst_len", pkt_len, 0);
      check("t5_rst_drop", drop_cnt, 0);
      @(posedge clk); #1;
      rst_n = 1;
      send(32'h62626262, 0, 0, 0);
      check("t5_tail_no_wr", wr_en, 0);
      send(32'h63636363, 1, 0, 0);
      check("t5_last_no_wr", wr_en, 0);
      check("t5_uncounted", drop_cnt, 0);
      idle(1);
      send(32'h70707070, 1, 1, 0); wr("t5_p0", 0, 32'h70707070);
      idle(0);
      check("t5_done", pkt_done, 1);
      check("t5_len", pkt_len, 1);
      // test 6: back-to-back single-word drops, 2-bit counter saturates at 3
      for (int i = 0; i < 5; i++) begin
         send(32'h80000000 + i, 1, 0, 0);
         check("t6_no_wr", wr_en, 0);
         check("t6_drop", drop_cnt, i + 1);
         check("t6_drop_sat", s_drop_cnt, i < 3 ? i + 1 : 3);
      end
      check("t6_owned", buf_owned, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
